// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Width of a down-counter that must hold n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Divide-by-zero quotient: all ones in the low n bits (n <= 64).
  function automatic logic [63:0] dbz_quotient(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response handshake bundle between the CPU datapath and seq_divider.
interface seq_divider_if #(parameter int N = 16) ();
  logic         req_valid;
  logic         req_ready;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output req_valid, is_signed, dividend, divisor, resp_ready,
    input  req_ready, resp_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  req_valid, is_signed, dividend, divisor, resp_ready,
    output req_ready, resp_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift, trial subtract, restore.
module div_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_rem,
  input  logic [N-1:0] i_quo,
  input  logic [N:0]   i_div,
  output logic [N-1:0] o_rem,
  output logic [N-1:0] o_quo
);

  logic [N:0] w_shift;
  logic       w_ge;

  assign w_shift = {i_rem, i_quo[N-1]};
  assign w_ge    = (w_shift >= i_div);
  // The true difference is below the divisor, so N-bit modular subtraction is exact.
  assign o_rem   = w_ge ? (w_shift[N-1:0] - i_div[N-1:0]) : w_shift[N-1:0];
  assign o_quo   = {i_quo[N-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, N iterations per request.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor| or |divisor| == 1.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input logic         clk,
  input logic         rstn,
  seq_divider_if.slave bus
);

  localparam int           CW    = cnt_width(N);
  localparam logic [N-1:0] DBZ_Q = N'(dbz_quotient(N));

  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem_acc;
  logic [N-1:0]  r_quo_acc;
  logic [N:0]    r_ds_mag;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_dbz;

  logic          w_dd_neg;
  logic          w_ds_neg;
  logic [N-1:0]  w_dd_mag;
  logic [N:0]    w_ds_mag;
  logic          w_ds_zero;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;

  assign w_dd_neg  = bus.is_signed & bus.dividend[N-1];
  assign w_ds_neg  = bus.is_signed & bus.divisor[N-1];
  // Negating MIN in N bits gives 2^(N-1), which is the right unsigned magnitude.
  assign w_dd_mag  = w_dd_neg ? -bus.dividend : bus.dividend;
  assign w_ds_mag  = {1'b0, (w_ds_neg ? -bus.divisor : bus.divisor)};
  assign w_ds_zero = (bus.divisor == '0);

  div_step #(.N(N)) u_step (
    .i_rem (r_rem_acc),
    .i_quo (r_quo_acc),
    .i_div (r_ds_mag),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem_acc    <= '0;
      r_quo_acc    <= '0;
      r_ds_mag     <= '0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_dbz       <= 1'b0;
            r_sign_q    <= w_dd_neg ^ w_ds_neg;
            r_sign_r    <= w_dd_neg;
            r_rem_acc   <= '0;
            r_quo_acc   <= w_dd_mag;
            r_ds_mag    <= w_ds_mag;
            r_cnt       <= CW'(N - 1);
            if (w_ds_zero) begin
              r_state     <= DONE;
              r_quotient  <= DBZ_Q;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end
`ifdef DIV_EARLY_OUT_EN
            else if ({1'b0, w_dd_mag} < w_ds_mag) begin
              r_state     <= DONE;
              r_quotient  <= '0;
              r_remainder <= bus.dividend;
            end else if (w_ds_mag == (N+1)'(1)) begin
              r_state     <= DONE;
              r_quotient  <= (w_dd_neg ^ w_ds_neg) ? -w_dd_mag : w_dd_mag;
              r_remainder <= '0;
            end
`endif
            else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem_acc <= w_rem_nxt;
          r_quo_acc <= w_quo_nxt;
          if (r_cnt == '0) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_quotient   <= r_sign_q ? -w_quo_nxt : w_quo_nxt;
            r_remainder  <= r_sign_r ? -w_rem_nxt : w_rem_nxt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // One-cycle paths enter DONE with results loaded; valid follows a cycle later.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=16), hand-computed vectors.
module tb_seq_divider;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  seq_divider_if #(.N(16)) bus ();

  seq_divider #(.N(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input bit early_case);
    return (early_case && EARLY) ? 1 : 16;
  endfunction

  // Accept one request, then count cycles until resp_valid (bounded).
  task automatic issue(input bit sgn, input logic [15:0] dd, input logic [15:0] ds,
                       output int lat, output bit rdy_low);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = dd;
    bus.divisor   = ds;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.dividend  = 16'hDEAD;
    bus.divisor   = 16'hBEEF;
    rdy_low = 1'b1;
    lat = 0;
    while (!bus.resp_valid && lat < 64) begin
      if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #2;
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dbz=%b, want 1 0 0000 0000 0",
               bus.req_ready, bus.resp_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    bit rdy_low;
    issue(1'b0, 16'd100, 16'd7, lat, rdy_low);
    n_vec++;
    if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL unsigned_100_7: q=%0d r=%0d dbz=%b, want 14 2 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    n_vec++;
    if (lat !== 16 || !rdy_low) begin
      n_err++;
      $display("FAIL unsigned_latency: lat=%0d rdy_low=%b, want 16 1", lat, rdy_low);
    end
    release_resp();
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL handshake_idle: vld=%b rdy=%b, want 0 1", bus.resp_valid, bus.req_ready);
    end
    issue(1'b0, 16'hFFFF, 16'h0010, lat, rdy_low);
    n_vec++;
    if (bus.quotient !== 16'h0FFF || bus.remainder !== 16'h000F || lat !== 16) begin
      n_err++;
      $display("FAIL unsigned_ffff_16: q=%h r=%h lat=%0d, want 0fff 000f 16",
               bus.quotient, bus.remainder, lat);
    end
    release_resp();
  endtask

  typedef struct {
    logic [15:0] dd;
    logic [15:0] ds;
    logic [15:0] q;
    logic [15:0] r;
  } svec_t;

  task automatic test_signed();
    svec_t v[4];
    int lat;
    bit rdy_low;
    v[0] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF};  // -7 / 2
    v[1] = '{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001};  // 7 / -2
    v[2] = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE};  // -100 / 7
    v[3] = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE};  // -100 / -7
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, v[i].dd, v[i].ds, lat, rdy_low);
      n_vec++;
      if (bus.quotient !== v[i].q || bus.remainder !== v[i].r || lat !== 16 || !rdy_low) begin
        n_err++;
        $display("FAIL signed_%0d: q=%h r=%h lat=%0d rdy_low=%b, want %h %h 16 1",
                 i, bus.quotient, bus.remainder, lat, rdy_low, v[i].q, v[i].r);
      end
      release_resp();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bit rdy_low;
    for (int s = 0; s < 2; s++) begin
      issue(s[0], 16'h1234, 16'h0000, lat, rdy_low);
      n_vec++;
      if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h1234 ||
          bus.div_by_zero !== 1'b1 || lat !== 1 || !rdy_low) begin
        n_err++;
        $display("FAIL div_by_zero_s%0d: q=%h r=%h dbz=%b lat=%0d, want ffff 1234 1 1",
                 s, bus.quotient, bus.remainder, bus.div_by_zero, lat);
      end
      release_resp();
    end
  endtask

  task automatic test_overflow();
    int lat;
    bit rdy_low;
    issue(1'b1, 16'h8000, 16'hFFFF, lat, rdy_low);
    n_vec++;
    if (bus.quotient !== 16'h8000 || bus.remainder !== 16'h0000 || bus.div_by_zero !== 1'b0 ||
        lat !== exp_lat(1'b1)) begin
      n_err++;
      $display("FAIL overflow: q=%h r=%h dbz=%b lat=%0d, want 8000 0000 0 %0d",
               bus.quotient, bus.remainder, bus.div_by_zero, lat, exp_lat(1'b1));
    end
    release_resp();
  endtask

  task automatic test_small_dividend();
    int lat;
    bit rdy_low;
    issue(1'b0, 16'd3, 16'd10, lat, rdy_low);
    n_vec++;
    if (bus.quotient !== 16'd0 || bus.remainder !== 16'd3 || lat !== exp_lat(1'b1)) begin
      n_err++;
      $display("FAIL small_3_10: q=%0d r=%0d lat=%0d, want 0 3 %0d",
               bus.quotient, bus.remainder, lat, exp_lat(1'b1));
    end
    release_resp();
    issue(1'b1, 16'hFFFB, 16'd1, lat, rdy_low);  // -5 / 1
    n_vec++;
    if (bus.quotient !== 16'hFFFB || bus.remainder !== 16'd0 || lat !== exp_lat(1'b1)) begin
      n_err++;
      $display("FAIL unit_divisor: q=%h r=%h lat=%0d, want fffb 0000 %0d",
               bus.quotient, bus.remainder, lat, exp_lat(1'b1));
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit rdy_low;
    bit stable;
    issue(1'b0, 16'd1000, 16'd10, lat, rdy_low);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.quotient !== 16'd100 || bus.remainder !== 16'd0) stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_err++;
      $display("FAIL backpressure_hold: vld=%b rdy=%b q=%0d r=%0d, want 1 0 100 0",
               bus.resp_valid, bus.req_ready, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.is_signed  = 1'b0;
    bus.dividend   = 16'd50;
    bus.divisor    = 16'd3;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: vld=%b rdy=%b, want 0 1", bus.resp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: rdy=%b, want 0", bus.req_ready);
    end
    lat = 0;
    while (!bus.resp_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (bus.quotient !== 16'd16 || bus.remainder !== 16'd2 || lat !== 16) begin
      n_err++;
      $display("FAIL b2b_result: q=%0d r=%0d lat=%0d, want 16 2 16",
               bus.quotient, bus.remainder, lat);
    end
    // Leave the 50/3 result pending so the reset test sees non-reset outputs beforehand.
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit rdy_low;
    release_resp();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 16'h1234;
    bus.divisor   = 16'h0005;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_calc: rdy=%b vld=%b q=%h r=%h dbz=%b, want 1 0 0000 0000 0",
               bus.req_ready, bus.resp_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rstn = 1'b1;
    issue(1'b0, 16'd65535, 16'd255, lat, rdy_low);
    n_vec++;
    if (bus.quotient !== 16'd257 || bus.remainder !== 16'd0 || lat !== 16) begin
      n_err++;
      $display("FAIL after_reset_65535_255: q=%0d r=%0d lat=%0d, want 257 0 16",
               bus.quotient, bus.remainder, lat);
    end
    release_resp();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.req_valid  = 1'b0;
    bus.is_signed  = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_small_dividend();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
